// File: rtl/gba_line_cache.sv
// rtl/gba_line_cache.sv - three-line RGB pixel cache between GBA capture and HDMI generator
//
// Ports:
//   pxlClk, rst            single clock, synchronous active-high reset
//   wrValid, wrRgb         capture pixel stream {R,G,B}
//   wrLineEnd              pulse after the last pixel of a line
//   wrFrameStart           pulse before pixel 0 of line 0
//   curPxl                 read column requested by the generator
//   nextLine               request to advance the read line
//   cacheUpdate            latch the read line for the next generator line
//   prevLineOut/curLineOut/nextLineOut
//                          registered 3x3 window, each {prevPxl, curPxl, nextPxl}
//   sameLine               no advance possible yet
//   newFrame               a new frame is ready at the read side
//   overflow               sticky: writer overwrote an unread line
//
// Build option: GBA_LINE_CACHE_EDGE_CLAMP_EN replicates edge pixels/lines
// instead of returning black for out-of-range neighbours.
module gba_line_cache #(
    parameter int LINE_W  = 240,
    parameter int FRAME_H = 160,
    parameter int SLOTS   = 4
) (
    input  logic        pxlClk,
    input  logic        rst,
    input  logic        wrValid,
    input  logic [23:0] wrRgb,
    input  logic        wrLineEnd,
    input  logic        wrFrameStart,
    input  logic [7:0]  curPxl,
    input  logic        nextLine,
    input  logic        cacheUpdate,
    output logic [71:0] prevLineOut,
    output logic [71:0] curLineOut,
    output logic [71:0] nextLineOut,
    output logic        sameLine,
    output logic        newFrame,
    output logic        overflow
);
    localparam int            AW         = $clog2(SLOTS * LINE_W);
    localparam int            RW         = $clog2(FRAME_H + 1);
    localparam logic [7:0]    LINE_END_X = 8'(LINE_W);
    localparam logic [7:0]    LAST_X     = 8'(LINE_W - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(FRAME_H - 1);
    localparam logic [RW-1:0] ROW_LIMIT  = RW'(FRAME_H);

`ifdef GBA_LINE_CACHE_EDGE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic [23:0] mem [SLOTS*LINE_W];

    function automatic logic [AW-1:0] ram_addr(input logic [1:0] slot, input logic [7:0] col);
        return AW'(slot) * AW'(LINE_W) + AW'(col);
    endfunction

    // ---------------- write side ----------------
    logic [1:0]    wr_slot;
    logic [7:0]    wr_x;
    logic [RW-1:0] wr_row;
    logic          frame_armed;    // a frame start has been seen since reset

    always_ff @(posedge pxlClk) begin
        if (wrValid && (wr_x < LINE_END_X))
            mem[ram_addr(wr_slot, wr_x)] <= wrRgb;
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            wr_slot     <= '0;
            wr_x        <= '0;
            wr_row      <= '0;
            frame_armed <= 1'b0;
        end else if (wrFrameStart) begin
            wr_slot     <= '0;
            wr_x        <= '0;
            wr_row      <= '0;
            frame_armed <= 1'b1;
        end else if (wrLineEnd) begin
            wr_slot <= wr_slot + 2'd1;
            wr_x    <= '0;
            if (wr_row != ROW_LIMIT)
                wr_row <= wr_row + RW'(1);
        end else if (wrValid && (wr_x != LINE_END_X)) begin
            // Park at LINE_W so surplus pixels are dropped instead of wrapping.
            wr_x <= wr_x + 8'd1;
        end
    end

    // ---------------- read-line bookkeeping ----------------
    logic [1:0]    rd_slot, rd_slot_n;
    logic [RW-1:0] rd_row, rd_row_n;
    logic [1:0]    avail, avail_n;
    logic          new_frame_n, ovf_set;
    logic [1:0]    line_sel;
    logic [RW-1:0] row_sel;

    logic line_done, frame_sync, adv;
    assign line_done  = wrLineEnd && !wrFrameStart;
    assign frame_sync = line_done && frame_armed && (wr_row == RW'(1));
    // Decided from live state, not the registered sameLine, so the cycle
    // right after reset cannot advance into lines that were never written.
    assign adv        = nextLine && (avail == 2'd2) && (rd_row != LAST_ROW);

    always_comb begin
        rd_slot_n   = rd_slot;
        rd_row_n    = rd_row;
        avail_n     = avail;
        new_frame_n = newFrame;
        ovf_set     = 1'b0;
        if (frame_sync) begin
            rd_slot_n   = '0;
            rd_row_n    = '0;
            avail_n     = 2'd1;
            new_frame_n = 1'b1;
        end else begin
            if (adv) begin
                rd_slot_n = rd_slot + 2'd1;
                rd_row_n  = rd_row + RW'(1);
            end
            if (adv && !line_done)
                avail_n = avail - 2'd1;
            else if (line_done && !adv) begin
                if (avail == 2'd2)
                    ovf_set = 1'b1;
                else
                    avail_n = avail + 2'd1;
            end
            if (wrFrameStart || (line_done && (wr_row == RW'(2))))
                new_frame_n = 1'b0;
        end
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            rd_slot  <= '0;
            rd_row   <= '0;
            avail    <= '0;
            newFrame <= 1'b0;
            overflow <= 1'b0;
            sameLine <= 1'b0;
            line_sel <= '0;
            row_sel  <= '0;
        end else begin
            rd_slot  <= rd_slot_n;
            rd_row   <= rd_row_n;
            avail    <= avail_n;
            newFrame <= new_frame_n;
            overflow <= overflow | ovf_set;
            sameLine <= (avail_n < 2'd2) || (rd_row_n == LAST_ROW);
            if (cacheUpdate) begin
                line_sel <= rd_slot;
                row_sel  <= rd_row;
            end
        end
    end

    // ---------------- 3x3 window ----------------
    logic [1:0]  slot_of [3];
    logic [23:0] prv_px [3];
    logic [23:0] cur_px [3];
    logic [23:0] nxt_px [3];
    logic [71:0] win [3];
    logic        col_ok, col_has_prev, col_has_next;

    assign slot_of[0]   = line_sel - 2'd1;
    assign slot_of[1]   = line_sel;
    assign slot_of[2]   = line_sel + 2'd1;
    assign col_ok       = curPxl < LINE_END_X;
    assign col_has_prev = col_ok && (curPxl != 8'd0);
    assign col_has_next = curPxl < LAST_X;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cur_px[i] = col_ok ? mem[ram_addr(slot_of[i], curPxl)] : 24'h0;
            prv_px[i] = col_has_prev ? mem[ram_addr(slot_of[i], curPxl - 8'd1)]
                                     : (CLAMP ? cur_px[i] : 24'h0);
            nxt_px[i] = col_has_next ? mem[ram_addr(slot_of[i], curPxl + 8'd1)]
                                     : (CLAMP ? cur_px[i] : 24'h0);
            win[i]    = {prv_px[i], cur_px[i], nxt_px[i]};
        end
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            prevLineOut <= '0;
            curLineOut  <= '0;
            nextLineOut <= '0;
        end else begin
            prevLineOut <= (row_sel != '0) ? win[0] : (CLAMP ? win[1] : 72'h0);
            curLineOut  <= win[1];
            nextLineOut <= (row_sel != LAST_ROW) ? win[2] : (CLAMP ? win[1] : 72'h0);
        end
    end

endmodule
